// File: rtl/dv_test_end_pkg.sv
// Shared types for the end-of-test sequencing controller.
package dv_test_end_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_DRAIN,
    ST_REPORT,
    ST_FINISHED
  } test_end_state_e;

  localparam logic VERDICT_PASS = 1'b1;
  localparam logic VERDICT_FAIL = 1'b0;

endpackage

// File: rtl/dv_test_end_ctrl_if.sv
// Pass/fail report handshake between the controller (master) and the status reporter (slave).
interface dv_test_end_ctrl_if;
  logic status_valid_o;
  logic status_ready_i;
  logic status_passed_o;

  modport master (output status_valid_o, output status_passed_o, input status_ready_i);
  modport slave  (input status_valid_o, input status_passed_o, output status_ready_i);
endinterface

// File: rtl/dv_test_end_ctrl.sv
// Collects per-source done/fail, runs drain window and global timeout, then issues
// exactly one pass/fail report request per reset.
module dv_test_end_ctrl
  import dv_test_end_pkg::*;
#(
  parameter int NumSrc        = 4,
  parameter int DrainCycles   = 16,
  parameter int TimeoutCycles = 100000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumSrc-1:0]   src_done_i,
  input  logic [NumSrc-1:0]   src_fail_i,
  dv_test_end_ctrl_if.master  status_if,
  output logic                timeout_o,
  output logic                late_fail_o,
  output logic [NumSrc-1:0]   done_mask_o
);

  localparam int TW = $clog2(TimeoutCycles);
  localparam int DW = $clog2(DrainCycles + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TimeoutCycles - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DrainCycles - 1);

  test_end_state_e    state_q, state_d;
  logic [TW-1:0]      timer_q;
  logic [DW-1:0]      drain_q;
  logic [NumSrc-1:0]  done_q;
  logic               fail_q, passed_q, timeout_q, late_q;
  logic               any_fail, all_done, enter_report;

  assign any_fail     = |src_fail_i;
  assign all_done     = &(done_q | src_done_i);
  assign enter_report = (state_q != ST_REPORT) && (state_d == ST_REPORT);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_ACTIVE;
    else       state_q <= state_d;
  end

  // Priority in ACTIVE: fail > all-done > timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACTIVE: begin
        if (any_fail)                  state_d = ST_REPORT;
        else if (all_done)             state_d = ST_DRAIN;
        else if (timer_q == TIMER_LAST) state_d = ST_REPORT;
      end
      ST_DRAIN: begin
        if (any_fail || drain_q == DRAIN_LAST) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (status_if.status_ready_i) state_d = ST_FINISHED;
      end
      default: state_d = ST_FINISHED;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q   <= '0;
      drain_q   <= '0;
      done_q    <= '0;
      fail_q    <= 1'b0;
      passed_q  <= VERDICT_FAIL;
      timeout_q <= 1'b0;
      late_q    <= 1'b0;
    end else begin
      if (state_q == ST_ACTIVE && state_d == ST_ACTIVE) timer_q <= timer_q + 1'b1;
      if (state_q == ST_ACTIVE)
        drain_q <= '0;
      else if (state_q == ST_DRAIN && state_d == ST_DRAIN)
        drain_q <= drain_q + 1'b1;
      if (state_q == ST_ACTIVE || state_q == ST_DRAIN) done_q <= done_q | src_done_i;
      if (state_q != ST_FINISHED && any_fail) fail_q <= 1'b1;
      if (state_q == ST_ACTIVE && state_d == ST_REPORT && !any_fail) timeout_q <= 1'b1;
      // Verdict is only a pass when the drain window ran out cleanly; it can
      // still drop while the request waits, but freezes once accepted.
      if (enter_report)
        passed_q <= (state_q == ST_DRAIN && !fail_q && !any_fail) ? VERDICT_PASS : VERDICT_FAIL;
      else if (state_q == ST_REPORT && any_fail && !status_if.status_ready_i)
        passed_q <= VERDICT_FAIL;
      if (state_q == ST_FINISHED && any_fail) late_q <= 1'b1;
    end
  end

  always_comb begin
    status_if.status_valid_o  = (state_q == ST_REPORT);
    status_if.status_passed_o = passed_q;
    timeout_o                 = timeout_q;
    late_fail_o               = late_q;
    done_mask_o               = done_q;
  end

endmodule

// File: tb/tb_dv_test_end_ctrl.sv
// Scoreboard bench for dv_test_end_ctrl: directed plan cases plus randomized schedules.
module tb_dv_test_end_ctrl;

  localparam int NS    = 4;
  localparam int DC    = 16;
  localparam int TO    = 50;
  localparam int L     = 100;
  localparam int NEVER = 9999;

  typedef int dvec_t [NS];
  typedef struct {
    int             rc;
    int             acc;
    bit             v0;
    bit             pacc;
    bit             tmo;
    logic [NS-1:0]  mask;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] done = '0;
  logic [NS-1:0] fail = '0;
  logic          tmo, late;
  logic [NS-1:0] mask;

  dv_test_end_ctrl_if sif();

  dv_test_end_ctrl #(.NumSrc(NS), .DrainCycles(DC), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst), .src_done_i(done), .src_fail_i(fail),
    .status_if(sif), .timeout_o(tmo), .late_fail_o(late), .done_mask_o(mask)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_chk = 0, n_err = 0, cyc = 0, hs_cnt = 0;
  int   rise = -1;
  bit   pv = 1'b0;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: records the valid rise, pops the expectation on every accepted handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv   = 1'b0;
        rise = -1;
      end else begin
        if (sif.status_valid_o && !pv) begin
          rise = cyc;
          if (sb.size() > 0) chk("passed_at_rise", sif.status_passed_o, sb[0].v0);
        end
        if (sif.status_valid_o && sif.status_ready_i) begin
          hs_cnt++;
          if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL handshake_without_expectation: got handshake, expected none (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            chk("valid_rise_cycle", rise, e.rc);
            chk("accept_cycle", cyc, e.acc);
            chk("passed_at_accept", sif.status_passed_o, e.pacc);
            chk("timeout_flag", tmo, e.tmo);
            chk("done_mask", mask, e.mask);
          end
        end
        pv = sif.status_valid_o;
      end
    end
  end

  // d: cycle each source signals done (NEVER = not at all); f: fail cycle on source fsrc.
  // rmode: 0 ready always, 1 random, 2 low for 8 report cycles, 3 never.
  task automatic run_scn(input dvec_t d, input bit lvl, input int f, input int fsrc,
                         input int rmode, input int abort);
    int t_all = 0, rc, acc, run;
    bit v, tm, pacc, lt;
    logic [NS-1:0] em;
    bit rdy [L];
    exp_t e;
    for (int i = 0; i < NS; i++) begin
      if (d[i] == NEVER) t_all = NEVER;
      else if (t_all != NEVER && d[i] > t_all) t_all = d[i];
    end
    if (f <= t_all && f <= TO - 1) begin
      rc = f + 1; v = 0; tm = 0;
    end else if (t_all <= TO - 1) begin
      tm = 0;
      if (f <= t_all + DC) begin rc = f + 1; v = 0; end
      else begin rc = t_all + DC + 1; v = 1; end
    end else begin
      rc = TO; v = 0; tm = 1;
    end
    for (int i = 0; i < NS; i++) em[i] = (d[i] < rc);
    for (int c = 0; c < L; c++) begin
      case (rmode)
        0:       rdy[c] = 1'b1;
        1:       rdy[c] = (c >= rc + 10) ? 1'b1 : 1'($urandom_range(0, 1));
        2:       rdy[c] = !(c >= rc && c < rc + 8);
        default: rdy[c] = 1'b0;
      endcase
    end
    acc = L;
    for (int c = L - 1; c >= rc; c--) if (rdy[c]) acc = c;
    pacc = v && !(f >= rc && f < acc);
    lt   = (f != NEVER) && (f > acc);
    if (abort < 0) begin
      e.rc = rc; e.acc = acc; e.v0 = v; e.pacc = pacc; e.tmo = tm; e.mask = em;
      sb.push_back(e);
    end

    hs_cnt = 0;
    rst = 1'b1; done = '0; fail = '0; sif.status_ready_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_outputs", {sif.status_valid_o, sif.status_passed_o, tmo, late, mask}, 0);
    run = (abort >= 0) ? abort : L;
    for (int c = 0; c < run; c++) begin
      for (int i = 0; i < NS; i++) done[i] = lvl ? (c >= d[i]) : (c == d[i]);
      fail = '0;
      if (c == f) fail[fsrc] = 1'b1;
      sif.status_ready_i = rdy[c];
      @(posedge clk); #1;
    end
    if (abort >= 0) begin
      rst = 1'b1; done = '0; fail = '0; sif.status_ready_i = 1'b0;
      @(posedge clk); #1;
      chk("abort_outputs_cleared", {sif.status_valid_o, sif.status_passed_o, tmo, late, mask}, 0);
      chk("abort_no_handshake", hs_cnt, 0);
    end else begin
      chk("final_valid_low", sif.status_valid_o, 0);
      chk("final_passed_frozen", sif.status_passed_o, pacc);
      chk("final_late_fail", late, lt);
      chk("handshake_count", hs_cnt, 1);
      chk("scoreboard_drained", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    dvec_t dv;
    sif.status_ready_i = 1'b0;
    dv = '{5, 9, 12, 20};                 run_scn(dv, 0, NEVER, 0, 0, -1);
    dv = '{NEVER, NEVER, NEVER, NEVER};   run_scn(dv, 0, 10, 2, 0, -1);
    dv = '{NEVER, NEVER, NEVER, NEVER};   run_scn(dv, 0, NEVER, 0, 0, -1);
    dv = '{1, 2, 3, 49};                  run_scn(dv, 0, NEVER, 0, 0, -1);
    dv = '{0, 0, 0, 0};                   run_scn(dv, 0, 19, 1, 2, -1);
    dv = '{0, 0, 0, 0};                   run_scn(dv, 1, 30, 3, 0, -1);
    dv = '{0, 0, 0, 0};                   run_scn(dv, 0, NEVER, 0, 3, 8);
    dv = '{0, 0, 0, 0};                   run_scn(dv, 0, NEVER, 0, 3, 20);
    dv = '{2, 7, 4, 11};                  run_scn(dv, 1, NEVER, 0, 1, -1);
    for (int n = 0; n < 24; n++) begin
      int f, fs;
      for (int i = 0; i < NS; i++)
        dv[i] = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 55));
      f  = ($urandom_range(0, 1) == 0) ? NEVER : int'($urandom_range(0, 90));
      fs = int'($urandom_range(0, NS - 1));
      run_scn(dv, 1'($urandom_range(0, 1)), f, fs, 1, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
